// File: rtl/r2r_4b_pkg.sv
// ============================================================================
// Module   : r2r_4b_pkg
// Brief    : Shared types, widths and the waveform mapper for the R2R wave
//            generator. Sine ROM present only when R2R_SINE_LUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package r2r_4b_pkg;

  localparam int PHASE_W = 5;
  localparam int CODE_W  = 4;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SIN = 2'd3
  } wave_e;

`ifdef R2R_SINE_LUT_EN
  // Offset-binary sine, mid-scale 8 at phase 0
  localparam logic [CODE_W-1:0] SINE_LUT [32] = '{
    4'd8,  4'd9,  4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15,
    4'd15, 4'd15, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd9,
    4'd8,  4'd7,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd1,
    4'd0,  4'd1,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd7
  };
`endif

  function automatic logic [CODE_W-1:0] wave_map(input logic [PHASE_W-1:0] phase,
                                                 input wave_e sel);
    logic [CODE_W-1:0] code;
    code = phase[4:1];
    case (sel)
      WAVE_SAW: code = phase[4:1];
      WAVE_TRI: code = phase[4] ? ~phase[3:0] : phase[3:0];
      WAVE_SQR: code = {CODE_W{phase[4]}};
      default: begin
`ifdef R2R_SINE_LUT_EN
        code = SINE_LUT[phase];
`else
        code = ~phase[4:1];
`endif
      end
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/r2r_4b_sync.sv
// ============================================================================
// Module   : r2r_4b_sync
// Brief    : Two-flop synchroniser bank with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r2r_4b_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/r2r_4b_wave_gen.sv
// ============================================================================
// Module   : r2r_4b_wave_gen
// Brief    : Prescaler -> 5-bit phase -> waveform mapper -> registered 4-bit
//            R2R DAC code. Build option: R2R_SINE_LUT_EN (sine ROM on sel 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r2r_4b_wave_gen
  import r2r_4b_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ext_data,
  input  logic        load_divider,
  input  logic [3:0]  data,
  input  logic [1:0]  wave_sel,
  output logic [3:0]  r2r_out,
  output logic        sample_tick
);

  localparam int SYNC_W = 9;

  logic [SYNC_W-1:0]  sync_in;
  logic [SYNC_W-1:0]  sync_out;
  logic               enable_s;
  logic               ext_s;
  logic               load_s;
  logic [1:0]         wave_bits_s;
  logic [3:0]         data_s;
  wave_e              wave_s;

  logic               load_q;
  logic               load_edge;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic [CODE_W-1:0]  map_code;

  assign sync_in = {enable, ext_data, load_divider, wave_sel, data};

  r2r_4b_sync #(.WIDTH(SYNC_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in),
    .q   (sync_out)
  );

  assign {enable_s, ext_s, load_s, wave_bits_s, data_s} = sync_out;
  assign wave_s    = wave_e'(wave_bits_s);
  assign load_edge = load_s & ~load_q;
  assign map_code  = wave_map(phase, wave_s);

  // A load edge takes priority over terminal count and suppresses the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q      <= 1'b0;
      div         <= DIV_RST;
      cnt         <= '0;
      phase       <= '0;
      sample_tick <= 1'b0;
      r2r_out     <= '0;
    end else begin
      load_q  <= load_s;
      r2r_out <= ext_s ? data_s : map_code;
      if (load_edge) begin
        div         <= {div[DIV_W-5:0], data_s};
        cnt         <= '0;
        sample_tick <= 1'b0;
      end else if (enable_s) begin
        if (cnt == div) begin
          cnt         <= '0;
          sample_tick <= 1'b1;
          phase       <= phase + PHASE_W'(1);
        end else begin
          cnt         <= cnt + DIV_W'(1);
          sample_tick <= 1'b0;
        end
      end else begin
        sample_tick <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_r2r_4b_wave_gen.sv
// ============================================================================
// Module   : tb_r2r_4b_wave_gen
// Brief    : Self-checking bench: arithmetic reference model plus directed
//            literal checks for the R2R wave generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r2r_4b_wave_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ext_data;
  logic       load_divider;
  logic [3:0] data;
  logic [1:0] wave_sel;
  logic [3:0] r2r_out;
  logic       sample_tick;

  always #50 clk = ~clk;

  r2r_4b_wave_gen dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ext_data     (ext_data),
    .load_divider (load_divider),
    .data         (data),
    .wave_sel     (wave_sel),
    .r2r_out      (r2r_out),
    .sample_tick  (sample_tick)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected code tables, one entry per phase 0..31
  int tri_exp [32] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                       15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
`ifdef R2R_SINE_LUT_EN
  int sel3_exp [32] = '{8, 9, 11, 12, 13, 14, 15, 15, 15, 15, 15, 14, 13, 12, 11, 9,
                        8, 7, 5, 4, 3, 2, 1, 1, 0, 1, 1, 2, 3, 4, 5, 7};
`else
  int sel3_exp [32] = '{15, 15, 14, 14, 13, 13, 12, 12, 11, 11, 10, 10, 9, 9, 8, 8,
                        7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
`endif

  function automatic int model_map(input int ph, input int sel);
    case (sel)
      0:       return ph / 2;
      1:       return (ph < 16) ? ph : 31 - ph;
      2:       return (ph >= 16) ? 15 : 0;
      default: begin
`ifdef R2R_SINE_LUT_EN
        return sel3_exp[ph];
`else
        return 15 - ph / 2;
`endif
      end
    endcase
  endfunction

  // Reference model: pins delayed two clocks, then the prescaler/phase rules
  logic [8:0] m_s1, m_s2;
  int  m_cnt, m_div, m_phase, m_out;
  bit  m_tick, m_lq;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    logic [8:0] q;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_cnt = 0; m_div = 999; m_phase = 0;
      m_out = 0; m_tick = 1'b0; m_lq = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      q = m_s2;
      m_out = q[7] ? int'(q[3:0]) : model_map(m_phase, int'(q[5:4]));
      if (q[6] && !m_lq) begin
        m_div  = (m_div * 16 + int'(q[3:0])) % 65536;
        m_cnt  = 0;
        m_tick = 1'b0;
      end else if (q[8]) begin
        if (m_cnt == m_div) begin
          m_cnt   = 0;
          m_tick  = 1'b1;
          m_phase = (m_phase + 1) % 32;
        end else begin
          m_cnt++;
          m_tick = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
      end
      m_lq = q[6];
      m_s2 = m_s1;
      m_s1 = {enable, ext_data, load_divider, wave_sel, data};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_r2r_out", int'(r2r_out), m_out);
      check("model_sample_tick", int'(sample_tick), int'(m_tick));
    end
  end

  task automatic load_nibble(input logic [3:0] n);
    data         = n;
    load_divider = 1'b1;
    repeat (3) @(negedge clk);
    load_divider = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Capture r2r_out, anchor on the phase-2 code, then compare phases 2..31
  task automatic cap_check(input string name, input int exp [32]);
    int cap [50];
    int a;
    int mism;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cap[i] = int'(r2r_out);
    end
    a = -1;
    for (int i = 0; i < 16; i++)
      if (a < 0 && cap[i] == exp[2]) a = i;
    check({name, "_anchor_found"}, (a >= 0) ? 1 : 0, 1);
    if (a >= 0) begin
      mism = 0;
      for (int j = 2; j < 32; j++)
        if (cap[a + j - 2] != exp[j]) mism++;
      check({name, "_sequence_mismatches"}, mism, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    int n;
    enable = 1'b0; ext_data = 1'b0; load_divider = 1'b0;
    data = 4'd0; wave_sel = 2'd0;
    do_reset();
    @(negedge clk);
    check("reset_r2r_out", int'(r2r_out), 0);
    check("reset_sample_tick", int'(sample_tick), 0);
    check("reset_div", int'(dut.div), 999);

    // Divider 999 -> 3 by shifting four nibbles, MS nibble first
    load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd3);
    check("div_after_load", int'(dut.div), 3);
    wave_sel = 2'd0;
    enable   = 1'b1;
    repeat (6) @(negedge clk);
    ticks = 0;
    repeat (40) begin
      @(negedge clk);
      ticks += int'(sample_tick);
    end
    check("ticks_in_40_clks_div3", ticks, 10);
    repeat (100) @(negedge clk);

    // Load edge lands on the cycle where cnt == div
    n = 0;
    while (m_cnt != 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("found_cnt1", (n < 20) ? 1 : 0, 1);
    data         = 4'd3;
    load_divider = 1'b1;
    repeat (3) @(negedge clk);
    check("load_tc_cnt", int'(dut.cnt), 0);
    check("load_tc_tick", int'(sample_tick), 0);
    check("load_tc_div", int'(dut.div), 51);
    load_divider = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-period
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_r2r_out", int'(r2r_out), 0);
    check("midrst_tick", int'(sample_tick), 0);
    check("midrst_div", int'(dut.div), 999);
    check("midrst_cnt", int'(dut.cnt), 0);
    check("midrst_phase", int'(dut.phase), 0);
    rst = 1'b0;

    // Triangle at div = 0
    wave_sel = 2'd1;
    load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd0);
    check("div_zero", int'(dut.div), 0);
    enable = 1'b1;
    cap_check("triangle", tri_exp);

    // Passthrough while the phase keeps running
    ext_data = 1'b1;
    data     = 4'hA;
    repeat (3) @(negedge clk);
    check("ext_passthrough", int'(r2r_out), 10);
    repeat (5) @(negedge clk);
    ext_data = 1'b0;
    repeat (10) @(negedge clk);

    // wave_sel = 3 from phase 0 at div = 0
    enable   = 1'b0;
    wave_sel = 2'd3;
    do_reset();
    load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd0); load_nibble(4'd0);
    check("sel3_phase0", int'(r2r_out), sel3_exp[0]);
    enable = 1'b1;
    cap_check("sel3", sel3_exp);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
